sdram_port_arbiter: RTL

- Shares the single SDRAM controller request port between three requesters: VGA DMA (port 0), TG68 CPU (port 1) and an auxiliary master (port 2).
- Sits between the requesters and the SDRAM controller that drives DRAM_* pins inside the TG68Test core.
- VGA has fixed priority, bounded by a starvation limit. CPU and aux alternate round-robin.
- One transaction is in flight at a time. A timeout watchdog detects a hung controller.

---
 rtl/sdram_port_arbiter_if.sv | 50 +++++
 rtl/sdram_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - bus bundle between requesters, arbiter and SDRAM controller
// Purpose: groups the three requester ports, the single SDRAM controller request
//          port and the arbiter status outputs into one connection.
// Signals:
//   req, addr0..2, wr, wdata0..2, bsel0..2 : requester side, into the arbiter
//   ack, rdata                             : completion back to the requesters
//   sd_req, sd_addr, sd_wr, sd_wdata, sd_bsel : request towards the SDRAM controller
//   sd_ack, sd_rdata                       : controller completion and read data
//   grant_id, timeout_err                  : status
// Modports: slave = arbiter view, master = system/requester/controller view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [2:0]        wr;
  logic [15:0]       wdata0;
  logic [15:0]       wdata1;
  logic [15:0]       wdata2;
  logic [1:0]        bsel0;
  logic [1:0]        bsel1;
  logic [1:0]        bsel2;
  logic [2:0]        ack;
  logic [15:0]       rdata;
  logic              sd_req;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_wr;
  logic [15:0]       sd_wdata;
  logic [1:0]        sd_bsel;
  logic              sd_ack;
  logic [15:0]       sd_rdata;
  logic [1:0]        grant_id;
  logic              timeout_err;

  modport slave (
    input  req, addr0, addr1, addr2, wr, wdata0, wdata1, wdata2,
           bsel0, bsel1, bsel2, sd_ack, sd_rdata,
    output ack, rdata, sd_req, sd_addr, sd_wr, sd_wdata, sd_bsel,
           grant_id, timeout_err
  );

  modport master (
    output req, addr0, addr1, addr2, wr, wdata0, wdata1, wdata2,
           bsel0, bsel1, bsel2, sd_ack, sd_rdata,
    input  ack, rdata, sd_req, sd_addr, sd_wr, sd_wdata, sd_bsel,
           grant_id, timeout_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - three-port arbiter in front of a single SDRAM controller port
// Purpose: shares one SDRAM request port between VGA DMA (port 0), CPU (port 1)
//          and an aux master (port 2). VGA has priority up to a burst limit while
//          others wait; CPU and aux alternate. One transaction in flight, with a
//          watchdog that forces completion if the controller never acknowledges.
// Ports:
//   clk      : system clock
//   reset_in : synchronous reset, active-high
//   bus      : sdram_port_arbiter_if.slave (requesters, SDRAM port, status)
module sdram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int VGA_BURST_MAX = 4,
  parameter int TIMEOUT       = 255
) (
  input logic                 clk,
  input logic                 reset_in,
  sdram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] BURST_MAX = 3'(VGA_BURST_MAX);
  localparam logic [7:0] WD_LIMIT  = 8'(TIMEOUT);
  localparam logic [1:0] GID_NONE  = 2'd3;

  state_t            state_q;
  logic [2:0]        vga_run_q;
  logic              rr_ptr_q;      // 0: CPU is next on a CPU/aux tie, 1: aux
  logic [7:0]        wd_cnt_q;
  logic [1:0]        grant_id_q;
  logic [2:0]        ack_q;
  logic [15:0]       rdata_q;
  logic              sd_req_q;
  logic [ADDR_W-1:0] sd_addr_q;
  logic              sd_wr_q;
  logic [15:0]       sd_wdata_q;
  logic [1:0]        sd_bsel_q;
  logic              timeout_err_q;

  logic              others_pending;
  logic              vga_wins;
  logic [1:0]        win_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_d;
  logic [15:0]       wdata_d;
  logic [1:0]        bsel_d;
  logic [7:0]        wd_cnt_d;
  logic [2:0]        ack_onehot;

  // Winner selection; only consumed in IDLE when at least one req bit is set.
  always_comb begin
    others_pending = bus.req[1] | bus.req[2];
    vga_wins       = bus.req[0] && ((vga_run_q < BURST_MAX) || !others_pending);
    win_d          = 2'd0;
    if (!vga_wins) begin
      if (bus.req[1] && bus.req[2]) win_d = rr_ptr_q ? 2'd2 : 2'd1;
      else if (bus.req[1])          win_d = 2'd1;
      else                          win_d = 2'd2;
    end
  end

  always_comb begin
    addr_d  = bus.addr0;
    wdata_d = bus.wdata0;
    bsel_d  = bus.bsel0;
    wr_d    = bus.wr[0];
    case (win_d)
      2'd1: begin
        addr_d  = bus.addr1;
        wdata_d = bus.wdata1;
        bsel_d  = bus.bsel1;
        wr_d    = bus.wr[1];
      end
      2'd2: begin
        addr_d  = bus.addr2;
        wdata_d = bus.wdata2;
        bsel_d  = bus.bsel2;
        wr_d    = bus.wr[2];
      end
      default: ;
    endcase
  end

  // The watchdog compares the count this cycle will reach, so sd_req stays
  // high for exactly TIMEOUT cycles before the forced completion.
  assign wd_cnt_d   = wd_cnt_q + 8'd1;
  assign ack_onehot = 3'b001 << grant_id_q;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q       <= IDLE;
      vga_run_q     <= 3'd0;
      rr_ptr_q      <= 1'b0;
      wd_cnt_q      <= 8'd0;
      grant_id_q    <= GID_NONE;
      ack_q         <= 3'b000;
      rdata_q       <= 16'h0000;
      sd_req_q      <= 1'b0;
      sd_addr_q     <= '0;
      sd_wr_q       <= 1'b0;
      sd_wdata_q    <= 16'h0000;
      sd_bsel_q     <= 2'b00;
      timeout_err_q <= 1'b0;
    end else begin
      ack_q <= 3'b000;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            sd_addr_q  <= addr_d;
            sd_wr_q    <= wr_d;
            sd_wdata_q <= wdata_d;
            sd_bsel_q  <= bsel_d;
            sd_req_q   <= 1'b1;
            grant_id_q <= win_d;
            state_q    <= BUSY;
            if (win_d == 2'd0) begin
              if (vga_run_q < BURST_MAX) vga_run_q <= vga_run_q + 3'd1;
            end else begin
              vga_run_q <= 3'd0;
              rr_ptr_q  <= (win_d == 2'd1);
            end
          end
        end
        BUSY: begin
          wd_cnt_q <= wd_cnt_d;
          // A real acknowledge wins over a watchdog expiry in the same cycle.
          if (bus.sd_ack) begin
            rdata_q  <= bus.sd_rdata;
            sd_req_q <= 1'b0;
            ack_q    <= ack_onehot;
            state_q  <= DONE;
          end else if (wd_cnt_d == WD_LIMIT) begin
            timeout_err_q <= 1'b1;
            rdata_q       <= 16'hFFFF;
            sd_req_q      <= 1'b0;
            ack_q         <= ack_onehot;
            state_q       <= DONE;
          end
        end
        DONE: begin
          grant_id_q <= GID_NONE;
          wd_cnt_q   <= 8'd0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.sd_req      = sd_req_q;
  assign bus.sd_addr     = sd_addr_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.sd_wdata    = sd_wdata_q;
  assign bus.sd_bsel     = sd_bsel_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
